// File: rtl/ps2_pkg.sv
// Shared PS/2 command/response bytes and the sequencer state encoding.
package ps2_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_SET_RES  = 8'hE8;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_ERROR  = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    localparam int         STATE_W  = 4;
    localparam logic [2:0] CMD_LAST = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        ST_PWRUP    = 4'd0,
        ST_SEND     = 4'd1,
        ST_TXWAIT   = 4'd2,
        ST_WAIT_ACK = 4'd3,
        ST_WAIT_BAT = 4'd4,
        ST_WAIT_ID  = 4'd5,
        ST_STREAM   = 4'd6,
        ST_FAIL     = 4'd7
    } init_state_t;

endpackage

// File: rtl/ps2_ms_timer.sv
// Millisecond timebase: free-running prescaler plus a clearable 10-bit ms count
// that saturates at 1023.
module ps2_ms_timer #(
    parameter int CLKFREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    output logic [9:0] ms_count
);
    localparam int TICK_CYC = (CLKFREQ / 1000 < 1) ? 1 : CLKFREQ / 1000;
    localparam int PW       = $clog2(TICK_CYC + 1);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == '0);

    // Prescaler down-counter; reload on terminal count gives one tick per ms.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     presc <= PW'(TICK_CYC - 1);
        else if (tick) presc <= PW'(TICK_CYC - 1);
        else           presc <= presc - 1'b1;
    end

    // Elapsed ms since the last clear; clear wins over a coincident tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               ms_count <= 10'd0;
        else if (clear)                          ms_count <= 10'd0;
        else if (tick && ms_count != 10'd1023)   ms_count <= ms_count + 10'd1;
    end

endmodule

// File: rtl/ps2_mouse_init_sequencer.sv
// Sequences a PS/2 mouse from power-up into stream mode and gates packet use.
//
// state    | meaning
// ---------+---------------------------------------------------------
// PWRUP    | settle 1 ms before talking to the mouse
// SEND     | strobe ROM[idx] into the transmitter once it is idle
// TXWAIT   | byte in flight, wait for tx_busy to fall
// WAIT_ACK | expect FA; FE resends, anything else restarts at FF
// WAIT_BAT | after reset ACK, expect self-test pass AA
// WAIT_ID  | after AA, expect device ID 00
// STREAM   | mouse streaming; watch for hot-plug AA,00
// FAIL     | retries exhausted; hold, then start over
module ps2_mouse_init_sequencer
    import ps2_pkg::*;
#(
    parameter int         CLKFREQ      = 50_000_000,
    parameter logic [7:0] SAMPLE_RATE  = 8'd40,
    parameter logic [7:0] RESOLUTION   = 8'd2,
    parameter int         MAX_RETRIES  = 3,
    parameter int         ACK_TMO_MS   = 25,
    parameter int         BAT_TMO_MS   = 750,
    parameter int         FAIL_HOLD_MS = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         restart,
    input  logic         tx_busy,
    output logic         tx_req,
    output logic [7:0]   tx_data,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic         stream_active,
    output logic         init_error,
    output logic [STATE_W-1:0] init_state
);
    localparam int RETRY_W = 4;

    init_state_t        state, state_next;
    logic [2:0]         idx, idx_next, bump_idx;
    logic [RETRY_W-1:0] retry, retry_next;
    logic               tx_req_next;
    logic [7:0]         tx_data_next;
    logic               err_next;
    logic               last_aa, last_aa_next;
    logic               busy_d, busy_fall;
    logic               bump;
    logic               ms_clear;
    logic [9:0]         ms_count;
    logic [7:0]         rom_byte;

    ps2_ms_timer #(.CLKFREQ(CLKFREQ)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (ms_clear),
        .ms_count (ms_count)
    );

    assign busy_fall     = busy_d & ~tx_busy;
    assign stream_active = (state == ST_STREAM);
    assign init_state    = state;

    // Command ROM: reset, set rate + arg, set resolution + arg, enable streaming.
    always_comb begin
        rom_byte = CMD_RESET;
        case (idx)
            3'd0:    rom_byte = CMD_RESET;
            3'd1:    rom_byte = CMD_SET_RATE;
            3'd2:    rom_byte = SAMPLE_RATE;
            3'd3:    rom_byte = CMD_SET_RES;
            3'd4:    rom_byte = RESOLUTION;
            3'd5:    rom_byte = CMD_ENABLE;
            default: rom_byte = CMD_RESET;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        retry_next   = retry;
        tx_req_next  = 1'b0;
        tx_data_next = tx_data;
        err_next     = init_error;
        last_aa_next = last_aa;
        bump         = 1'b0;
        bump_idx     = idx;

        case (state)
            ST_PWRUP: begin
                if (ms_count >= 10'd1) begin
                    state_next = ST_SEND;
                    idx_next   = 3'd0;
                    retry_next = '0;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_req_next  = 1'b1;
                    tx_data_next = rom_byte;
                    state_next   = ST_TXWAIT;
                end
            end
            ST_TXWAIT: begin
                if (busy_fall) state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (rx_valid) begin
                    if (rx_data == RSP_ACK) begin
                        if (idx == 3'd0)          state_next = ST_WAIT_BAT;
                        else if (idx == CMD_LAST) state_next = ST_STREAM;
                        else begin
                            idx_next   = idx + 3'd1;
                            retry_next = '0;
                            state_next = ST_SEND;
                        end
                    end else if (rx_data == RSP_RESEND) begin
                        bump = 1'b1;
                    end else begin
                        bump     = 1'b1;
                        bump_idx = 3'd0;
                    end
                end else if (ms_count >= 10'(ACK_TMO_MS)) begin
                    bump = 1'b1;
                end
            end
            ST_WAIT_BAT: begin
                if (rx_valid) begin
                    if (rx_data == RSP_BAT_OK) state_next = ST_WAIT_ID;
                    else begin
                        bump     = 1'b1;
                        bump_idx = 3'd0;
                    end
                end else if (ms_count >= 10'(BAT_TMO_MS)) begin
                    bump     = 1'b1;
                    bump_idx = 3'd0;
                end
            end
            ST_WAIT_ID: begin
                if (rx_valid) begin
                    if (rx_data == RSP_ID) begin
                        idx_next   = 3'd1;
                        retry_next = '0;
                        state_next = ST_SEND;
                    end else begin
                        bump     = 1'b1;
                        bump_idx = 3'd0;
                    end
                end else if (ms_count >= 10'(BAT_TMO_MS)) begin
                    bump     = 1'b1;
                    bump_idx = 3'd0;
                end
            end
            ST_STREAM: begin
                if (rx_valid) begin
                    last_aa_next = (rx_data == RSP_BAT_OK);
                    // One-byte lookbehind: a packet carrying AA,00 also re-configures.
                    if (last_aa && rx_data == RSP_ID) begin
                        idx_next   = 3'd1;
                        retry_next = '0;
                        state_next = ST_SEND;
                    end
                end
            end
            ST_FAIL: begin
                if (ms_count >= 10'(FAIL_HOLD_MS)) begin
                    state_next = ST_PWRUP;
                    retry_next = '0;
                end
            end
            default: state_next = ST_PWRUP;
        endcase

        if (bump) begin
            if (retry >= RETRY_W'(MAX_RETRIES)) begin
                state_next = ST_FAIL;
            end else begin
                retry_next = retry + 1'b1;
                idx_next   = bump_idx;
                state_next = ST_SEND;
            end
        end

        if (restart) begin
            state_next  = ST_PWRUP;
            tx_req_next = 1'b0;
            retry_next  = '0;
        end

        if (state_next == ST_FAIL)   err_next = 1'b1;
        if (state_next == ST_STREAM) begin
            err_next   = 1'b0;
            retry_next = '0;
        end
        if (state_next != ST_STREAM) last_aa_next = 1'b0;

        ms_clear = (state_next != state) || restart;
    end

    // State, sequencing counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_PWRUP;
            idx        <= 3'd0;
            retry      <= '0;
            tx_req     <= 1'b0;
            tx_data    <= 8'h00;
            init_error <= 1'b0;
            last_aa    <= 1'b0;
            busy_d     <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            retry      <= retry_next;
            tx_req     <= tx_req_next;
            tx_data    <= tx_data_next;
            init_error <= err_next;
            last_aa    <= last_aa_next;
            busy_d     <= tx_busy;
        end
    end

endmodule

// File: tb/tb_ps2_mouse_init_sequencer.sv
// Directed bench for the PS/2 mouse init sequencer (10 clock cycles per ms).
module tb_ps2_mouse_init_sequencer;

    logic       clk = 1'b0;
    logic       reset, restart, tx_busy, rx_valid;
    logic [7:0] rx_data;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       stream_active, init_error;
    logic [3:0] init_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ps2_mouse_init_sequencer #(.CLKFREQ(10_000)) dut (
        .clk           (clk),
        .reset         (reset),
        .restart       (restart),
        .tx_busy       (tx_busy),
        .tx_req        (tx_req),
        .tx_data       (tx_data),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .stream_active (stream_active),
        .init_error    (init_error),
        .init_state    (init_state)
    );

    // Wait (bounded) for a send strobe, then emulate the transmitter being busy.
    task automatic wait_tx(input int budget, output logic [7:0] b, output int waited, output bit ok);
        ok = 1'b0; waited = 0; b = 8'h00;
        while (waited < budget && !ok) begin
            @(negedge clk);
            waited++;
            if (tx_req === 1'b1) begin
                ok = 1'b1;
                b  = tx_data;
            end
        end
        if (ok) begin
            tx_busy = 1'b1;
            repeat (4) @(negedge clk);
            tx_busy = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req: got %b required 0", tx_req); end
        n_checks++;
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
        n_checks++;
        if (stream_active !== 1'b0) begin n_fail++; $display("FAIL reset_stream: got %b required 0", stream_active); end
        n_checks++;
        if (init_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b required 0", init_error); end
        n_checks++;
        if (init_state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", init_state); end
    endtask

    task automatic test_clean_boot();
        logic [7:0] seq [0:5];
        logic [7:0] b; int w; bit ok;
        seq = '{8'hFF, 8'hF3, 8'h28, 8'hE8, 8'h02, 8'hF4};
        for (int i = 0; i < 6; i++) begin
            wait_tx(200, b, w, ok);
            n_checks++;
            if (!ok || b !== seq[i]) begin
                n_fail++;
                $display("FAIL boot_tx%0d: got %h (strobe seen %0d) required %h", i, b, ok, seq[i]);
            end
            if (i == 5) begin
                n_checks++;
                if (stream_active !== 1'b0) begin n_fail++; $display("FAIL boot_stream_early: got %b required 0", stream_active); end
            end
            send_rx(8'hFA);
            if (i == 0) begin send_rx(8'hAA); send_rx(8'h00); end
        end
        n_checks++;
        if (stream_active !== 1'b1) begin n_fail++; $display("FAIL boot_stream: got %b required 1", stream_active); end
        n_checks++;
        if (init_state !== 4'd6) begin n_fail++; $display("FAIL boot_state: got %0d required 6", init_state); end
    endtask

    task automatic test_hot_plug();
        logic [7:0] seq [0:4];
        logic [7:0] b; int w; bit ok;
        seq = '{8'hF3, 8'h28, 8'hE8, 8'h02, 8'hF4};
        send_rx(8'h08); send_rx(8'hAA); send_rx(8'h05); send_rx(8'h00);
        n_checks++;
        if (stream_active !== 1'b1) begin n_fail++; $display("FAIL hotplug_no_pair: got %b required 1", stream_active); end
        send_rx(8'hAA); send_rx(8'h00);
        n_checks++;
        if (stream_active !== 1'b0) begin n_fail++; $display("FAIL hotplug_drop: got %b required 0", stream_active); end
        n_checks++;
        if (init_state !== 4'd1) begin n_fail++; $display("FAIL hotplug_state: got %0d required 1", init_state); end
        for (int i = 0; i < 5; i++) begin
            wait_tx(200, b, w, ok);
            n_checks++;
            if (!ok || b !== seq[i]) begin
                n_fail++;
                $display("FAIL hotplug_tx%0d: got %h (strobe seen %0d) required %h", i, b, ok, seq[i]);
            end
            send_rx(8'hFA);
        end
        n_checks++;
        if (stream_active !== 1'b1) begin n_fail++; $display("FAIL hotplug_return: got %b required 1", stream_active); end
    endtask

    task automatic test_resend();
        logic [7:0] seq [0:6];
        logic [7:0] rsp [0:6];
        logic [7:0] b; int w; bit ok;
        seq = '{8'hFF, 8'hF3, 8'hF3, 8'h28, 8'hE8, 8'h02, 8'hF4};
        rsp = '{8'hFA, 8'hFE, 8'hFA, 8'hFA, 8'hFA, 8'hFA, 8'hFA};
        pulse_restart();
        n_checks++;
        if (init_state !== 4'd0 || stream_active !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_pwrup: state %0d stream %b required 0/0", init_state, stream_active);
        end
        for (int i = 0; i < 7; i++) begin
            wait_tx(200, b, w, ok);
            n_checks++;
            if (!ok || b !== seq[i]) begin
                n_fail++;
                $display("FAIL resend_tx%0d: got %h (strobe seen %0d) required %h", i, b, ok, seq[i]);
            end
            send_rx(rsp[i]);
            if (i == 0) begin send_rx(8'hAA); send_rx(8'h00); end
        end
        n_checks++;
        if (stream_active !== 1'b1 || init_error !== 1'b0) begin
            n_fail++;
            $display("FAIL resend_end: stream %b error %b required 1/0", stream_active, init_error);
        end
    endtask

    task automatic test_bat_failure();
        logic [7:0] seq [0:6];
        logic [7:0] b; int w; bit ok;
        seq = '{8'hFF, 8'hFF, 8'hF3, 8'h28, 8'hE8, 8'h02, 8'hF4};
        pulse_restart();
        for (int i = 0; i < 7; i++) begin
            wait_tx(200, b, w, ok);
            n_checks++;
            if (!ok || b !== seq[i]) begin
                n_fail++;
                $display("FAIL bat_tx%0d: got %h (strobe seen %0d) required %h", i, b, ok, seq[i]);
            end
            send_rx(8'hFA);
            if (i == 0) send_rx(8'hFC);
            if (i == 1) begin send_rx(8'hAA); send_rx(8'h00); end
        end
        n_checks++;
        if (stream_active !== 1'b1) begin n_fail++; $display("FAIL bat_stream: got %b required 1", stream_active); end
    endtask

    task automatic test_silent();
        logic [7:0] seq [0:4];
        logic [7:0] b; int w; bit ok; int f;
        seq = '{8'hF3, 8'h28, 8'hE8, 8'h02, 8'hF4};
        pulse_restart();
        for (int k = 0; k < 4; k++) begin
            wait_tx((k == 0) ? 30 : 300, b, w, ok);
            n_checks++;
            if (!ok || b !== 8'hFF) begin
                n_fail++;
                $display("FAIL silent_tx%0d: got %h (strobe seen %0d) required ff", k, b, ok);
            end
            if (k > 0) begin
                n_checks++;
                if (w < 238 || w > 258) begin
                    n_fail++;
                    $display("FAIL silent_gap%0d: got %0d cycles required 238..258", k, w);
                end
            end
        end
        f = 0;
        while (f < 300 && init_state !== 4'd7) begin @(negedge clk); f++; end
        n_checks++;
        if (init_state !== 4'd7) begin n_fail++; $display("FAIL silent_fail_state: got %0d required 7", init_state); end
        n_checks++;
        if (init_error !== 1'b1 || stream_active !== 1'b0) begin
            n_fail++;
            $display("FAIL silent_error: error %b stream %b required 1/0", init_error, stream_active);
        end
        n_checks++;
        if (f < 238 || f > 258) begin n_fail++; $display("FAIL silent_fail_delay: got %0d cycles required 238..258", f); end
        wait_tx(10100, b, w, ok);
        n_checks++;
        if (!ok || b !== 8'hFF || w < 9990 || w > 10020) begin
            n_fail++;
            $display("FAIL silent_restart_tx: got %h after %0d cycles (seen %0d) required ff after 9990..10020", b, w, ok);
        end
        n_checks++;
        if (init_error !== 1'b1) begin n_fail++; $display("FAIL silent_error_held: got %b required 1", init_error); end
        send_rx(8'hFA); send_rx(8'hAA); send_rx(8'h00);
        for (int i = 0; i < 5; i++) begin
            wait_tx(200, b, w, ok);
            n_checks++;
            if (!ok || b !== seq[i]) begin
                n_fail++;
                $display("FAIL silent_recover_tx%0d: got %h (strobe seen %0d) required %h", i, b, ok, seq[i]);
            end
            send_rx(8'hFA);
        end
        n_checks++;
        if (stream_active !== 1'b1 || init_error !== 1'b0) begin
            n_fail++;
            $display("FAIL silent_recover: stream %b error %b required 1/0", stream_active, init_error);
        end
    endtask

    task automatic test_restart_priority();
        logic [7:0] seq [0:3];
        logic [7:0] b; int w; bit ok;
        seq = '{8'hFF, 8'hF3, 8'h28, 8'hE8};
        pulse_restart();
        for (int i = 0; i < 4; i++) begin
            wait_tx(200, b, w, ok);
            n_checks++;
            if (!ok || b !== seq[i]) begin
                n_fail++;
                $display("FAIL prio_tx%0d: got %h (strobe seen %0d) required %h", i, b, ok, seq[i]);
            end
            if (i < 3) send_rx(8'hFA);
            if (i == 0) begin send_rx(8'hAA); send_rx(8'h00); end
        end
        restart  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hFA;
        @(negedge clk);
        restart  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        n_checks++;
        if (init_state !== 4'd0 || tx_req !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_pwrup: state %0d tx_req %b required 0/0", init_state, tx_req);
        end
        wait_tx(30, b, w, ok);
        n_checks++;
        if (!ok || b !== 8'hFF || w > 13) begin
            n_fail++;
            $display("FAIL prio_next_tx: got %h after %0d cycles (seen %0d) required ff within 13", b, w, ok);
        end
    endtask

    task automatic test_async_reset();
        int w; logic [7:0] b; bit ok;
        pulse_restart();
        w = 0;
        while (w < 30 && tx_req !== 1'b1) begin @(negedge clk); w++; end
        n_checks++;
        if (tx_req !== 1'b1 || tx_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL areset_setup: tx_req %b data %h required 1/ff", tx_req, tx_data);
        end
        tx_busy = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (tx_req !== 1'b0 || tx_data !== 8'h00 || stream_active !== 1'b0 || init_error !== 1'b0 || init_state !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_outputs: tx_req %b data %h stream %b error %b state %0d required 0/00/0/0/0",
                     tx_req, tx_data, stream_active, init_error, init_state);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wait_tx(30, b, w, ok);
        n_checks++;
        if (!ok || b !== 8'hFF) begin n_fail++; $display("FAIL areset_next_tx: got %h (seen %0d) required ff", b, ok); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        restart  = 1'b0;
        tx_busy  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_clean_boot();
        test_hot_plug();
        test_resend();
        test_bat_failure();
        test_silent();
        test_restart_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
